// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle shift-add multiply / restoring divide with HI/LO registers.
// Define MULTDIV_SIGNED_EN to let op[1] select signed operation; otherwise every operation is unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, step, res;
    logic [WIDTH-1:0]   opb, a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic               is_div;
`ifdef MULTDIV_SIGNED_EN
    logic sgn, neg_res, neg_a;
`else
    logic unused_sign;
    assign unused_sign = op[1];
`endif

    assign busy = state != IDLE;

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
`ifdef MULTDIV_SIGNED_EN
        sgn   = ~op[1];
        a_mag = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn && b[WIDTH-1]) ? -b : b;
        quo   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem   = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res   = is_div ? {rem, quo} : (neg_res ? -acc : acc);
`else
        a_mag = a;
        b_mag = b;
        quo   = acc[WIDTH-1:0];
        rem   = acc[2*WIDTH-1:WIDTH];
        res   = is_div ? {rem, quo} : acc;
`endif
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opb};
        step    = !is_div ? {mul_sum, acc[WIDTH-1:1]} :
                  diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                  {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            neg_res  <= 1'b0;
            neg_a    <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (op[0] && b == '0) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else begin
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        opb    <= b_mag;
                        is_div <= op[0];
                        cnt    <= CNT_INIT;
                        state  <= RUN;
`ifdef MULTDIV_SIGNED_EN
                        neg_res <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_a   <= sgn & a[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    acc <= step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIN;
                end
                FIN: begin
                    {hi, lo} <= res;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed tests of mult_div_unit (WIDTH = 32); expectations follow MULTDIV_SIGNED_EN.
module tb_mult_div_unit;
    localparam int W = 32;
    logic clk = 0, reset = 0, start = 0;
    logic [1:0] op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic busy, done, div_zero;
    logic [W-1:0] hi, lo;
    int checks = 0, failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo); end
        @(negedge clk) reset = 1;
    endtask

    task automatic test_umul;
        int n;
        launch(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL umul_busy got %b want 1", busy); end
        wait_done(n);
        checks++; if (n !== 33) begin failures++; $display("FAIL umul_latency got %0d want 33", n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL umul_busy_done got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL umul_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL umul_lo got %h want 00000001", lo); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL umul_div_zero got %b want 0", div_zero); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL umul_done_pulse got %b want 0", done); end
    endtask

    task automatic test_smul;
        int n;
        logic [W-1:0] eh;
        launch(2'b00, -32'sd3, 32'd5);
        wait_done(n);
`ifdef MULTDIV_SIGNED_EN
        eh = 32'hFFFF_FFFF;
`else
        eh = 32'h0000_0004;
`endif
        checks++; if (n !== 33) begin failures++; $display("FAIL smul_latency got %0d want 33", n); end
        checks++; if (hi !== eh) begin failures++; $display("FAIL smul_hi got %h want %h", hi, eh); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL smul_lo got %h want fffffff1", lo); end
    endtask

    task automatic test_div;
        int n;
        logic [W-1:0] eq, er;
        launch(2'b01, -32'sd7, 32'd2);
        wait_done(n);
`ifdef MULTDIV_SIGNED_EN
        eq = 32'hFFFF_FFFD; er = 32'hFFFF_FFFF;
`else
        eq = 32'h7FFF_FFFC; er = 32'h0000_0001;
`endif
        checks++; if (n !== 33) begin failures++; $display("FAIL sdiv_latency got %0d want 33", n); end
        checks++; if (lo !== eq) begin failures++; $display("FAIL sdiv_lo got %h want %h", lo, eq); end
        checks++; if (hi !== er) begin failures++; $display("FAIL sdiv_hi got %h want %h", hi, er); end
        launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
`ifdef MULTDIV_SIGNED_EN
        eq = 32'h8000_0000; er = 32'h0;
`else
        eq = 32'h0; er = 32'h8000_0000;
`endif
        checks++; if (lo !== eq) begin failures++; $display("FAIL ovf_lo got %h want %h", lo, eq); end
        checks++; if (hi !== er) begin failures++; $display("FAIL ovf_hi got %h want %h", hi, er); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL ovf_div_zero got %b want 0", div_zero); end
        launch(2'b11, 32'd100, 32'd7);
        wait_done(n);
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL udiv_hilo got %0d/%0d want 2/14", hi, lo); end
    endtask

    task automatic test_div_zero;
        int n;
        launch(2'b10, 32'h1234_5678, 32'h0001_0000);
        wait_done(n);
        checks++; if ({hi, lo} !== 64'h0000_1234_5678_0000) begin failures++; $display("FAIL preload_hilo got %h_%h want 00001234_56780000", hi, lo); end
        launch(2'b11, 32'hDEAD, 32'h0);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL dz_done got %b want 1", done); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got %b want 1", div_zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0000_1234_5678_0000) begin failures++; $display("FAIL dz_hilo got %h_%h want 00001234_56780000", hi, lo); end
        @(posedge clk); #1;
        checks++; if ({done, div_zero, busy} !== 3'b000) begin failures++; $display("FAIL dz_clear got %b want 000", {done, div_zero, busy}); end
    endtask

    task automatic test_ignore_start;
        int pulses = 0, first = 0;
        launch(2'b10, 32'd7, 32'd9);
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if (n == 10) begin a = 3; b = 3; op = 2'b11; start = 1; end
            if (n == 11) start = 0;
            if (done) begin pulses++; if (first == 0) first = n; end
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL ign_pulses got %0d want 1", pulses); end
        checks++; if (first !== 33) begin failures++; $display("FAIL ign_latency got %0d want 33", first); end
        checks++; if ({hi, lo} !== {32'd0, 32'd63}) begin failures++; $display("FAIL ign_hilo got %0d/%0d want 0/63", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int n;
        launch(2'b10, 32'd6, 32'd7);
        wait_done(n);
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL b2b_first_lo got %0d want 42", lo); end
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1;
        @(posedge clk); #1 start = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy %b want 1", busy); end
        wait_done(n);
        checks++; if (n !== 33) begin failures++; $display("FAIL b2b_latency got %0d want 33", n); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL b2b_hilo got %0d/%0d want 2/14", hi, lo); end
    endtask

    task automatic test_async_reset;
        int n, pulses = 0;
        launch(2'b11, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #3 reset = 0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL rst_hilo got %h_%h want 0", hi, lo); end
        repeat (2) @(negedge clk);
        reset = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_no_done got %0d active cycles want 0", pulses); end
        launch(2'b11, 32'd1000, 32'd3);
        wait_done(n);
        checks++; if (n !== 33) begin failures++; $display("FAIL rst_restart_latency got %0d want 33", n); end
        checks++; if ({hi, lo} !== {32'd1, 32'd333}) begin failures++; $display("FAIL rst_restart_hilo got %0d/%0d want 1/333", hi, lo); end
    endtask

    initial begin
        test_reset;
        test_umul;
        test_smul;
        test_div;
        test_div_zero;
        test_ignore_start;
        test_back_to_back;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
